// File: rtl/udma_rxbuffer.sv
// udma_rxbuffer: packs 16-bit HyperBus PHY beats into 32-bit little-endian uDMA words.
// Define UDMA_RXBUF_ERR_EN to add the sticky err_o protocol-error flag.
module udma_rxbuffer #(
  parameter int TRANS_SIZE = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [TRANS_SIZE-1:0] len_i,
  input  logic [1:0]            mem_sel_i,
  input  logic                  cfg_addr_space_i,
  input  logic                  hyper_odd_saaddr_i,
  input  logic                  src_valid_i,
  output logic                  src_ready_o,
  input  logic [15:0]           data_i,
  output logic                  dst_valid_o,
  input  logic                  dst_ready_i,
  output logic [31:0]           data_o,
  output logic                  dst_last_o,
  output logic                  busy_o,
  output logic                  done_o
`ifdef UDMA_RXBUF_ERR_EN
  , output logic                err_o
`endif
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
  state_t state_q, state_d;
  logic swap_q, reg_q, odd_q, first_q, first_d;
  logic [TRANS_SIZE-1:0] left_q, left_d, left_nx;
  logic [39:0] acc_q, acc_d, merged;
  logic [2:0] cnt_q, cnt_d, tot;
  logic [31:0] data_q, data_d;
  logic valid_q, valid_d, last_q, last_d, done_q, done_d;
  logic [7:0] lo, hi;
  logic [15:0] pair, masked;
  logic [1:0] avail, take;
  logic odd_beat, beat, out_free;
  assign lo = swap_q ? data_i[15:8] : data_i[7:0];
  assign hi = swap_q ? data_i[7:0] : data_i[15:8];
  assign odd_beat = first_q & odd_q;
  assign pair = odd_beat ? {8'h00, hi} : {hi, lo};
  assign avail = odd_beat ? 2'd1 : 2'd2;
  assign take = (left_q < TRANS_SIZE'(avail)) ? 2'(left_q) : avail;
  assign masked = (take == 2'd1) ? {8'h00, pair[7:0]} : pair;
  assign merged = acc_q | ({24'h0, masked} << {cnt_q, 3'b000});
  assign tot = cnt_q + {1'b0, take};
  assign left_nx = left_q - TRANS_SIZE'(take);
  assign out_free = !valid_q | dst_ready_i;
  assign src_ready_o = (state_q == ACTIVE) & (left_q != '0) & out_free;
  assign beat = src_valid_i & src_ready_o;
  assign dst_valid_o = valid_q;
  assign data_o = data_q;
  assign dst_last_o = last_q;
  assign busy_o = state_q != IDLE;
  assign done_o = done_q;
  always_comb begin
    state_d = state_q;
    left_d = left_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    data_d = data_q;
    last_d = last_q;
    valid_d = valid_q & !dst_ready_i;
    first_d = first_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        done_d = len_i == '0;
        state_d = (len_i == '0) ? IDLE : ACTIVE;
        left_d = cfg_addr_space_i ? TRANS_SIZE'(1) : len_i;
        first_d = 1'b1;
        acc_d = '0;
        cnt_d = '0;
      end
      ACTIVE: if (beat && reg_q) begin
        data_d = {16'h0, data_i};
        last_d = 1'b1;
        valid_d = 1'b1;
        left_d = '0;
        first_d = 1'b0;
        state_d = DRAIN;
      end else if (beat) begin
        first_d = 1'b0;
        left_d = left_nx;
        state_d = (left_nx == '0) ? DRAIN : ACTIVE;
        // A 5-byte total at the end emits 4 now and leaves 1 for DRAIN to flush
        if (tot >= 3'd4 || left_nx == '0) begin
          data_d = merged[31:0];
          last_d = (left_nx == '0) && (tot <= 3'd4);
          valid_d = 1'b1;
          acc_d = (tot >= 3'd4) ? merged >> 32 : '0;
          cnt_d = (tot >= 3'd4) ? tot - 3'd4 : '0;
        end else begin
          acc_d = merged;
          cnt_d = tot;
        end
      end
      DRAIN: if (cnt_q != '0 && out_free) begin
        data_d = acc_q[31:0];
        last_d = 1'b1;
        valid_d = 1'b1;
        acc_d = '0;
        cnt_d = '0;
      end else if (valid_q && dst_ready_i && last_q) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      left_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      last_q <= 1'b0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      done_q <= 1'b0;
      swap_q <= 1'b0;
      reg_q <= 1'b0;
      odd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      left_q <= left_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      last_q <= last_d;
      valid_q <= valid_d;
      first_q <= first_d;
      done_q <= done_d;
      if (state_q == IDLE && start_i) begin
        swap_q <= mem_sel_i[1];
        reg_q <= cfg_addr_space_i;
        odd_q <= hyper_odd_saaddr_i & !cfg_addr_space_i;
      end
    end
  end
`ifdef UDMA_RXBUF_ERR_EN
  logic err_q;
  always_ff @(posedge clk_i)
    err_q <= (rst_i || start_i) ? 1'b0 : err_q | (src_valid_i & (state_q != ACTIVE));
  assign err_o = err_q;
`endif
endmodule
